round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/cyberwar_pkg.sv | 18 +
 rtl/score_counter.sv | 25 ++
 rtl/round_controller.sv | 108 ++++++++++
 tb/tb_round_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cyberwar_pkg.sv
// Shared types and defaults for the cyberwar round logic: FSM states,
// winner encodings and default game constants.
package cyberwar_pkg;

    typedef enum logic [1:0] {
        PLAY,
        RESTART,
        OVER
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int unsigned DEF_WIN_SCORE   = 7;
    localparam int unsigned DEF_HOLD_CYCLES = 2;

endpackage

// File: rtl/score_counter.sv
// Saturating per-player score counter; stops at MAX_COUNT and never wraps.
module score_counter #(
    parameter int unsigned SCORE_W   = 3,
    parameter int unsigned MAX_COUNT = 7
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               atMax
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_COUNT);

    assign atMax = (count == MAX_VAL);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (inc && !atMax) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/round_controller.sv
// Round controller: scores edge hits, holds the playfield in restart between
// points, and latches the winner once a player reaches WIN_SCORE.
module round_controller
    import cyberwar_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               L,
    input  logic               R,
    input  logic               edgeL,
    input  logic               edgeR,
    output logic               res,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic [1:0]         winner,
    output logic               gameOver
);

    localparam logic [SCORE_W-1:0] LAST_PT = SCORE_W'(WIN_SCORE - 1);
    localparam logic [3:0]         HOLD_M1 = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] hold;
    logic       pointL, pointR;
    logic       atMaxL, atMaxR;

    // Each press condition excludes the opposite press, so both can never fire together.
    assign pointL = (state == PLAY) && edgeL && L && !R;
    assign pointR = (state == PLAY) && edgeR && R && !L;

    score_counter #(
        .SCORE_W  (SCORE_W),
        .MAX_COUNT(WIN_SCORE)
    ) u_scoreL (
        .Clock(Clock),
        .Reset(Reset),
        .inc  (pointL),
        .count(scoreL),
        .atMax(atMaxL)
    );

    score_counter #(
        .SCORE_W  (SCORE_W),
        .MAX_COUNT(WIN_SCORE)
    ) u_scoreR (
        .Clock(Clock),
        .Reset(Reset),
        .inc  (pointR),
        .count(scoreR),
        .atMax(atMaxR)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= PLAY;
            hold     <= '0;
            res      <= 1'b0;
            gameOver <= 1'b0;
            winner   <= WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (pointL && !atMaxL) begin
                        res <= 1'b1;
                        if (scoreL == LAST_PT) begin
                            state    <= OVER;
                            gameOver <= 1'b1;
                            winner   <= WIN_LEFT;
                        end else begin
                            state <= RESTART;
                            hold  <= HOLD_M1;
                        end
                    end else if (pointR && !atMaxR) begin
                        res <= 1'b1;
                        if (scoreR == LAST_PT) begin
                            state    <= OVER;
                            gameOver <= 1'b1;
                            winner   <= WIN_RIGHT;
                        end else begin
                            state <= RESTART;
                            hold  <= HOLD_M1;
                        end
                    end
                end
                RESTART: begin
                    if (hold == '0) begin
                        state <= PLAY;
                        res   <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                OVER: begin
                    res <= 1'b1;
                end
                default: begin
                    state <= PLAY;
                    res   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Randomized and directed bench for round_controller against a behavioural
// score/hold model (WIN_SCORE=3, HOLD_CYCLES=2).
module tb_round_controller;

    localparam int unsigned WIN  = 3;
    localparam int unsigned HOLD = 2;
    localparam int unsigned SW   = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          L = 1'b0, R = 1'b0, edgeL = 1'b0, edgeR = 1'b0;
    logic          res, gameOver;
    logic [SW-1:0] scoreL, scoreR;
    logic [1:0]    winner;

    int passCnt = 0;
    int totalCnt = 0;

    // Behavioural model: scores, remaining restart cycles, game-over flag.
    int       mL, mR, mHold;
    bit       mOver;
    int       mWin;

    round_controller #(
        .WIN_SCORE  (WIN),
        .SCORE_W    (SW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .L       (L),
        .R       (R),
        .edgeL   (edgeL),
        .edgeR   (edgeR),
        .res     (res),
        .scoreL  (scoreL),
        .scoreR  (scoreR),
        .winner  (winner),
        .gameOver(gameOver)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mL = 0; mR = 0; mHold = 0; mOver = 0; mWin = 0;
        end else if (mOver) begin
            // game finished: nothing moves until reset
        end else if (mHold > 0) begin
            mHold = mHold - 1;
        end else if (edgeL && L && !R) begin
            mL = mL + 1;
            if (mL == WIN) begin mOver = 1; mWin = 1; end
            else mHold = HOLD;
        end else if (edgeR && R && !L) begin
            mR = mR + 1;
            if (mR == WIN) begin mOver = 1; mWin = 2; end
            else mHold = HOLD;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    always @(negedge Clock) begin
        if (!Reset) begin
            chk("model.scoreL", int'(scoreL), mL);
            chk("model.scoreR", int'(scoreR), mR);
            chk("model.res", int'(res), int'((mHold > 0) || mOver));
            chk("model.gameOver", int'(gameOver), int'(mOver));
            chk("model.winner", int'(winner), mWin);
        end
    end

    // Drive inputs at negedge, return just after the following rising edge.
    task automatic step(input logic l, input logic r, input logic el, input logic er);
        @(negedge Clock);
        L = l; R = r; edgeL = el; edgeR = er;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Mid-cycle asynchronous reset pulse with immediate output checks.
    task automatic pulse_reset(input string tag);
        @(negedge Clock);
        L = 0; R = 0; edgeL = 0; edgeR = 0;
        #2 Reset = 1'b1;
        #1;
        chk({tag, ".rst.res"}, int'(res), 0);
        chk({tag, ".rst.scoreL"}, int'(scoreL), 0);
        chk({tag, ".rst.scoreR"}, int'(scoreR), 0);
        chk({tag, ".rst.winner"}, int'(winner), 0);
        chk({tag, ".rst.gameOver"}, int'(gameOver), 0);
        #1 Reset = 1'b0;
    endtask

    initial begin
        #12 Reset = 1'b0;
        pulse_reset("r036");

        // Single left point, two restart cycles, back to play.
        step(1, 0, 1, 0);
        chk("r037.scoreL", int'(scoreL), 1);
        chk("r037.res1", int'(res), 1);
        idle(1);
        chk("r037.res2", int'(res), 1);
        idle(1);
        chk("r037.resOff", int'(res), 0);
        chk("r037.scoreR", int'(scoreR), 0);

        // Both presses score nothing; then right alone scores.
        step(1, 1, 0, 1);
        chk("r038.noScore", int'(scoreR), 0);
        chk("r038.noRes", int'(res), 0);
        step(0, 1, 0, 1);
        chk("r038.scoreR", int'(scoreR), 1);
        chk("r038.res1", int'(res), 1);
        idle(1);
        chk("r038.res2", int'(res), 1);
        idle(1);
        chk("r038.resOff", int'(res), 0);

        // Held left press: scores once per play visit only.
        pulse_reset("r039");
        step(1, 0, 1, 0);
        chk("r039.first", int'(scoreL), 1);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("r039.ignored", int'(scoreL), 1);
        step(1, 0, 1, 0);
        chk("r039.second", int'(scoreL), 2);
        idle(2);

        // Right player wins; game frozen until reset.
        pulse_reset("r040");
        for (int p = 0; p < 3; p++) begin
            step(0, 1, 0, 1);
            idle(2);
        end
        chk("r040.scoreR", int'(scoreR), 3);
        chk("r040.gameOver", int'(gameOver), 1);
        chk("r040.winner", int'(winner), 2);
        chk("r040.res", int'(res), 1);
        step(0, 1, 0, 1);
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        chk("r040.frozenR", int'(scoreR), 3);
        chk("r040.frozenL", int'(scoreL), 0);
        chk("r040.frozenWin", int'(winner), 2);
        pulse_reset("r040b");

        // Reset during the second restart cycle abandons the round.
        step(1, 0, 1, 0);
        idle(1);
        chk("r041.inRestart", int'(res), 1);
        pulse_reset("r041");
        step(1, 0, 1, 0);
        chk("r041.scoreL", int'(scoreL), 1);
        idle(2);

        // Randomized play against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                pulse_reset("rand");
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge Clock);
        #1;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
